// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus between pc_fetch (master) and instruction memory (slave).
interface pc_fetch_if #(
  parameter int unsigned PC_W    = 5,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Program-counter register and request/acknowledge instruction-fetch sequencer.
// Optional feature: define PC_ALIGN_CHECK_EN to flag a misaligned accepted pc_next
// (sticky misalign_err) and halt instead of fetching from it.
module pc_fetch #(
  parameter int unsigned     PC_W     = 5,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_next,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus_4,
  pc_fetch_if.master         imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               stall,
  input  logic               halt,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic               misalign_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  logic   req_q;
  logic   accept_c;
  logic   bad_align_c;

  // Sequential-PC feed back to the next-PC mux; wraps modulo 2^PC_W.
  assign pc_plus_4 = pc + PC_W'(4);

  // Fetch address is the registered PC, so it is stable for the whole request.
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  // Decode takes the held instruction only when not stalled.
  assign accept_c = (state == HOLD) && instr_ready && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic err_q;

  assign bad_align_c  = |pc_next[1:0];
  assign misalign_err = err_q;

  // Sticky flag for an accepted non-word-aligned next PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept_c && bad_align_c) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bad_align_c  = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Fetch sequencer: IDLE dead cycle, REQ until ack, HOLD until accept, HALTED until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (accept_c) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            if (fetch_cnt != '1) begin
              fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (halt || bad_align_c) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch;
  localparam int unsigned PC_W    = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 16;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [PC_W-1:0]    pc_next = '0;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus_4;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic               stall = 1'b0;
  logic               halt = 1'b0;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;
  logic               misalign_err;

  pc_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pc_fetch #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(5'd0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc(pc), .pc_plus_4(pc_plus_4),
    .imem(bus), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .stall(stall), .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder settings.
  int          lat = 0;
  int          age = 0;
  bit          stray = 1'b0;
  bit          fixed_data = 1'b0;
  logic [31:0] fixed_word = 32'hDEADBEEF;

  // One clock; new inputs and memory response are driven at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bus.imem_req === 1'b1) begin
      bus.imem_ack = (age >= lat);
      age++;
    end else begin
      bus.imem_ack = stray;
      age = 0;
    end
    bus.imem_rdata = fixed_data ? fixed_word : $urandom;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (instr_valid !== 1'b1) check("wait_valid_timeout", 64'(instr_valid), 64'd1);
  endtask

  task automatic accept(input logic [PC_W-1:0] nxt, input logic h);
    pc_next = nxt;
    halt = h;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    halt = 1'b0;
  endtask

  // Behavioural model: fetch phase flags, updated at each rising edge and compared 1 time unit later.
  bit          m_known = 1'b0;
  bit          m_dead, m_req, m_valid, m_halted, m_err;
  logic [4:0]  m_pc;
  logic [31:0] m_instr;
  int          m_cnt;

  initial begin
    while (!done) begin
      @(posedge clk);
      if (reset) begin
        m_known = 1'b1; m_dead = 1'b1; m_req = 1'b0; m_valid = 1'b0;
        m_halted = 1'b0; m_err = 1'b0; m_pc = 5'd0; m_instr = 32'd0; m_cnt = 0;
      end else if (m_known) begin
        if (m_dead) begin
          m_dead = 1'b0;
          m_req  = 1'b1;
        end else if (m_req) begin
          if (bus.imem_ack) begin
            m_instr = bus.imem_rdata;
            m_valid = 1'b1;
            m_req   = 1'b0;
          end
        end else if (m_valid && instr_ready && !stall) begin
          m_pc    = pc_next;
          m_valid = 1'b0;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (ALIGN_CHK && pc_next[1:0] != 2'b00) m_err = 1'b1;
          if (halt || (ALIGN_CHK && pc_next[1:0] != 2'b00)) m_halted = 1'b1;
          else m_req = 1'b1;
        end
      end
      #1;
      if (m_known) begin
        check("pc", 64'(pc), 64'(m_pc));
        check("pc_plus_4", 64'(pc_plus_4), 64'((int'(m_pc) + 4) % 32));
        check("imem_req", 64'(bus.imem_req), 64'(m_req));
        check("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
        check("instr", 64'(instr), 64'(m_instr));
        check("instr_valid", 64'(instr_valid), 64'(m_valid));
        check("halted", 64'(halted), 64'(m_halted));
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
        check("misalign_err", 64'(misalign_err), 64'(m_err));
      end
    end
  end

  initial begin
    logic [31:0] saved;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;

    // Reset, then sequential fetches 0, 4, 8.
    reset = 1'b1;
    tick(); tick();
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_cnt", 64'(fetch_cnt), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    tick();
    check("first_req", 64'(bus.imem_req), 64'd1);
    check("first_addr", 64'(bus.imem_addr), 64'd0);
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      check("seq_pc", 64'(pc), 64'(4 * k));
      accept(5'(4 * (k + 1)), 1'b0);
    end
    check("seq_cnt", 64'(fetch_cnt), 64'd3);
    check("seq_pc_end", 64'(pc), 64'd12);

    // Wrap-around at pc = 28.
    wait_valid();
    accept(5'd28, 1'b0);
    check("wrap_pc", 64'(pc), 64'd28);
    check("wrap_plus4", 64'(pc_plus_4), 64'd0);
    fixed_data = 1'b1;
    wait_valid();
    accept(pc_plus_4, 1'b0);
    check("wrap_pc0", 64'(pc), 64'd0);
    check("wrap_req", 64'(bus.imem_req), 64'd1);
    check("wrap_addr", 64'(bus.imem_addr), 64'd0);

    // Stall blocks acceptance for 3 cycles, accept on the 4th.
    wait_valid();
    check("stall_instr0", 64'(instr), 64'hDEADBEEF);
    pc_next = 5'd16;
    instr_ready = 1'b1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", 64'(pc), 64'd0);
      check("stall_instr", 64'(instr), 64'hDEADBEEF);
      check("stall_valid", 64'(instr_valid), 64'd1);
    end
    stall = 1'b0;
    lat = 4;
    tick();
    instr_ready = 1'b0;
    fixed_data = 1'b0;
    check("stall_accept_pc", 64'(pc), 64'd16);
    check("stall_accept_valid", 64'(instr_valid), 64'd0);
    check("stall_cnt", 64'(fetch_cnt), 64'd6);

    // Slow memory: request held stable while waiting for ack.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("slow_req", 64'(bus.imem_req), 64'd1);
      check("slow_addr", 64'(bus.imem_addr), 64'd16);
    end
    wait_valid();
    lat = 0;

    // Stray ack in HOLD leaves instr alone.
    saved = instr;
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stray_instr", 64'(instr), 64'(saved));
      check("stray_valid", 64'(instr_valid), 64'd1);
    end
    stray = 1'b0;

    // Halt with accept, then no fetches.
    accept(5'd20, 1'b1);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_pc", 64'(pc), 64'd20);
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("halt_req", 64'(bus.imem_req), 64'd0);
      check("halt_stay", 64'(halted), 64'd1);
    end
    instr_ready = 1'b0;

    // Reset mid-fetch with an ack pending in the same cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 1;
    tick();
    check("midreq_req", 64'(bus.imem_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_pc", 64'(pc), 64'd0);
    check("midrst_req", 64'(bus.imem_req), 64'd0);
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_instr", 64'(instr), 64'd0);
    reset = 1'b0;
    lat = 0;

    // Misaligned next PC.
    tick();
    wait_valid();
    accept(5'd6, 1'b0);
    check("mis_pc", 64'(pc), 64'd6);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_err", 64'(misalign_err), 64'd1);
    check("mis_halted", 64'(halted), 64'd1);
    check("mis_req", 64'(bus.imem_req), 64'd0);
`else
    check("mis_err", 64'(misalign_err), 64'd0);
    check("mis_req", 64'(bus.imem_req), 64'd1);
    check("mis_addr", 64'(bus.imem_addr), 64'd6);
`endif

    // Randomized traffic against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) pc_next = 5'($urandom);
      else pc_next = pc_plus_4;
      lat   = int'($urandom_range(0, 3));
      stray = 1'($urandom_range(0, 1));
      if (halted === 1'b1) reset = ($urandom_range(0, 7) == 0);
      else reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
